// File: rtl/parking_slot_controller.sv
// rtl/parking_slot_controller.sv - 4-slot car park occupancy register with entry and exit gate sequencers
module parking_slot_controller #(
    parameter int GATE_TICKS = 250
) (
    input  logic       clk_500Hz,
    input  logic       reset,
    input  logic       car_at_entry,
    input  logic       car_at_exit,
    input  logic [1:0] exit_slot,
    output logic       entry_gate,
    output logic       exit_gate,
    output logic [3:0] occupancy,
    output logic [2:0] capacity,
    output logic [1:0] first_empty,
    output logic       full,
    output logic [1:0] assigned_slot,
    output logic       entry_denied,
    output logic       exit_error
);

    typedef enum logic [1:0] {E_IDLE, E_OPEN, E_CLEAR} entry_state_t;
    typedef enum logic [1:0] {X_IDLE, X_OPEN, X_CLEAR} exit_state_t;

    localparam logic [9:0] OPEN_LOAD = 10'(GATE_TICKS - 1);

    entry_state_t e_state;
    exit_state_t  x_state;
    logic [9:0]   e_count;
    logic [9:0]   x_count;
    logic         prev_entry;
    logic         prev_exit;

    logic         entry_rise;
    logic         exit_rise;
    logic         grant;
    logic         release_slot;
    logic [3:0]   set_mask;
    logic [3:0]   clr_mask;

    always_comb begin
        capacity = 3'd4 - ({2'b00, occupancy[0]} + {2'b00, occupancy[1]}
                         + {2'b00, occupancy[2]} + {2'b00, occupancy[3]});
        full = (occupancy == 4'b1111);
        first_empty = 2'd0;
        if (!occupancy[0])      first_empty = 2'd0;
        else if (!occupancy[1]) first_empty = 2'd1;
        else if (!occupancy[2]) first_empty = 2'd2;
        else if (!occupancy[3]) first_empty = 2'd3;
    end

    // Both decisions look at occupancy before this edge, so an exit cannot free a slot for a same-edge entry.
    always_comb begin
        entry_rise   = car_at_entry & ~prev_entry;
        exit_rise    = car_at_exit & ~prev_exit;
        grant        = (e_state == E_IDLE) && entry_rise && !full;
        release_slot = (x_state == X_IDLE) && exit_rise && occupancy[exit_slot];
        set_mask     = grant ? (4'b0001 << first_empty) : 4'b0000;
        clr_mask     = release_slot ? (4'b0001 << exit_slot) : 4'b0000;
    end

    always_ff @(posedge clk_500Hz or posedge reset) begin
        if (reset) begin
            e_state       <= E_IDLE;
            x_state       <= X_IDLE;
            e_count       <= '0;
            x_count       <= '0;
            prev_entry    <= 1'b0;
            prev_exit     <= 1'b0;
            occupancy     <= 4'b0000;
            assigned_slot <= 2'd0;
            entry_gate    <= 1'b0;
            exit_gate     <= 1'b0;
            entry_denied  <= 1'b0;
            exit_error    <= 1'b0;
        end else begin
            prev_entry   <= car_at_entry;
            prev_exit    <= car_at_exit;
            occupancy    <= (occupancy | set_mask) & ~clr_mask;
            entry_denied <= (e_state == E_IDLE) && entry_rise && full;
            exit_error   <= (x_state == X_IDLE) && exit_rise && !occupancy[exit_slot];

            case (e_state)
                E_IDLE: begin
                    if (grant) begin
                        e_state       <= E_OPEN;
                        e_count       <= OPEN_LOAD;
                        assigned_slot <= first_empty;
                        entry_gate    <= 1'b1;
                    end
                end
                E_OPEN: begin
                    if (e_count == 10'd0) e_state <= E_CLEAR;
                    else                  e_count <= e_count - 10'd1;
                end
                E_CLEAR: begin
                    if (!car_at_entry) begin
                        e_state    <= E_IDLE;
                        entry_gate <= 1'b0;
                    end
                end
                default: begin
                    e_state    <= E_IDLE;
                    entry_gate <= 1'b0;
                end
            endcase

            case (x_state)
                X_IDLE: begin
                    if (release_slot) begin
                        x_state   <= X_OPEN;
                        x_count   <= OPEN_LOAD;
                        exit_gate <= 1'b1;
                    end
                end
                X_OPEN: begin
                    if (x_count == 10'd0) x_state <= X_CLEAR;
                    else                  x_count <= x_count - 10'd1;
                end
                X_CLEAR: begin
                    if (!car_at_exit) begin
                        x_state   <= X_IDLE;
                        exit_gate <= 1'b0;
                    end
                end
                default: begin
                    x_state   <= X_IDLE;
                    exit_gate <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/parking_slot_controller.md
# parking_slot_controller

Sequences a 4-slot car park. It owns the slot occupancy register and runs independent entry-gate and exit-gate state machines driven by car sensors. It produces the `capacity` / `first_empty` pair consumed by `ParkingDisplay`, so it sits between the gate sensors and the display on the same 500 Hz clock.

## Interface
- `GATE_TICKS`, default 250: minimum cycles a gate stays open after a granted event (0.5 s at 500 Hz); legal range 1..1023.
- `clk_500Hz`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `car_at_entry`  in  1  entry sensor level, synchronous to `clk_500Hz`.
- `car_at_exit`  in  1  exit sensor level, synchronous.
- `exit_slot`  in  2  slot being vacated; sampled on the same edge as the `car_at_exit` rise.
- `entry_gate`  out  1  entry barrier open.
- `exit_gate`  out  1  exit barrier open.
- `occupancy`  out  4  bit i = slot i occupied.
- `capacity`  out  3  number of empty slots, 0..4.
- `first_empty`  out  2  lowest-index empty slot; 0 when full.
- `full`  out  1  all 4 slots occupied.
- `assigned_slot`  out  2  slot granted to the last admitted car; held until the next grant.
- `entry_denied`  out  1  one-cycle pulse: entry rise while full.
- `exit_error`  out  1  one-cycle pulse: exit request on an empty slot.

## Operation
- Rise detection: `prev_entry` and `prev_exit` registers. A rise is a cycle where the sensor is 1 and the previous sample was 0. The prev registers update every cycle in every state.
- `capacity` = 4 − popcount(`occupancy`). `first_empty` = priority encode of the lowest 0 bit. `full` = (`occupancy` == 4'b1111). All three are combinational from the `occupancy` register.
- Entry FSM states: E_IDLE, E_OPEN, E_CLEAR.
  - E_IDLE + entry rise + not full: set `occupancy[first_empty]`, load `assigned_slot` = `first_empty`, load counter = GATE_TICKS−1, go to E_OPEN.
  - E_IDLE + entry rise + full: pulse `entry_denied`; stay in E_IDLE.
  - E_OPEN: counter decrements each cycle; at 0 go to E_CLEAR.
  - E_CLEAR: stay while `car_at_entry` = 1; go to E_IDLE on the first edge it samples 0.
  - `entry_gate` = 1 in E_OPEN and E_CLEAR.
- Exit FSM states: X_IDLE, X_OPEN, X_CLEAR, with its own counter.
  - X_IDLE + exit rise + `occupancy[exit_slot]` = 1: clear that bit, go to X_OPEN.
  - X_IDLE + exit rise + bit = 0: pulse `exit_error`; stay in X_IDLE.
  - X_OPEN and X_CLEAR behave as in the entry FSM, using `car_at_exit`. `exit_gate` = 1 in X_OPEN and X_CLEAR.
- Rises arriving while an FSM is not idle are ignored: no pulse, no occupancy change.
- Simultaneous entry grant and exit release in the same cycle: both bit updates apply.
  - The entry decision uses `occupancy` before the release. A full lot with a simultaneous exit denies the entry; the count ends at capacity 1.
  - Entry always targets an empty bit and exit an occupied bit, so the two never touch the same bit.
- Reset asserted mid-operation closes both gates immediately and clears `occupancy`; cars in transit are forgotten.

## Timing
- Reset values:
  - `occupancy` 0, `capacity` 4, `first_empty` 0, `full` 0.
  - `entry_gate` 0, `exit_gate` 0, `assigned_slot` 0.
  - `entry_denied` 0, `exit_error` 0.
  - prev registers 0, both FSMs idle, counters 0.
- A rise sampled at edge N takes effect at edge N. From that edge: the gate goes high, the `occupancy` bit changes, `capacity` / `first_empty` / `full` reflect the change, and any `entry_denied` / `exit_error` pulse is high for exactly cycle N..N+1.
- Gate open time is GATE_TICKS cycles in OPEN plus the cycles spent in CLEAR.
  - If the sensor is already low when CLEAR is entered, the gate drops one edge later: minimum high time GATE_TICKS+1 cycles.
- A held-high sensor generates one rise only. A new car requires the sensor to go low and then high again.
- All outputs are registered or combinational from registers only; there are no combinational paths from inputs.

## Test plan
- Reset check: assert `reset` for 2 cycles → `capacity`=4, `first_empty`=0, `full`=0, both gates 0; release `reset` → outputs unchanged.
- Fill the lot (GATE_TICKS=3): four entry pulses, each 2 cycles high, spaced 10 cycles apart →
  - `capacity` steps 3, 2, 1, 0;
  - `assigned_slot` 0, 1, 2, 3;
  - `first_empty` 1, 2, 3, 0;
  - `full`=1;
  - each `entry_gate` high exactly 4 cycles.
- Denial: fifth entry rise while full → `entry_denied` high 1 cycle, `entry_gate` stays 0, `occupancy` stays 4'b1111.
- Exit:
  - `exit_slot`=1 with an exit rise → `occupancy`=4'b1101, `capacity`=1, `first_empty`=1, `exit_gate` high.
  - Repeat with `exit_slot`=1 → `exit_error` pulse; `occupancy` unchanged.
- Simultaneous events with the lot full: entry rise and exit rise (slot 2) on the same edge → `entry_denied` pulse, `occupancy`=4'b1011, `capacity`=1. Next entry rise → slot 2 granted, `capacity`=0.
- Gate hold and reset mid-operation:
  - Hold `car_at_entry` high for 20 cycles → `entry_gate` stays high until one edge after the sensor drops.
  - Then assert `reset` while `exit_gate` is open → both gates 0 and `occupancy`=0 immediately, without waiting for a clock edge.
